// File: rtl/dp_arbiter_if.sv
// Requester, datapath and status signals of dp_arbiter bundled as one interface.
// The master modport is the arbiter's view; slave is the view of the sequencers and datapath.
interface dp_arbiter_if #(
    parameter int unsigned OPW  = 3,
    parameter int unsigned ARGW = 2
);
    logic            REQ0;
    logic [OPW-1:0]  OPC0;
    logic [ARGW-1:0] OPA0;
    logic [ARGW-1:0] OPB0;
    logic            REQ1;
    logic [OPW-1:0]  OPC1;
    logic [ARGW-1:0] OPA1;
    logic [ARGW-1:0] OPB1;
    logic            GNT0;
    logic            GNT1;
    logic            ZF0;
    logic            ZF1;
    logic            ZERO_FLAG;
    logic [OPW-1:0]  opcode;
    logic [ARGW-1:0] operand1;
    logic [ARGW-1:0] operand2;
    logic            BUSY;
    logic            PREEMPT;

    modport master (
        input  REQ0, OPC0, OPA0, OPB0, REQ1, OPC1, OPA1, OPB1, ZERO_FLAG,
        output GNT0, GNT1, ZF0, ZF1, opcode, operand1, operand2, BUSY, PREEMPT
    );

    modport slave (
        output REQ0, OPC0, OPA0, OPB0, REQ1, OPC1, OPA1, OPB1, ZERO_FLAG,
        input  GNT0, GNT1, ZF0, ZF1, opcode, operand1, operand2, BUSY, PREEMPT
    );
endinterface

// File: rtl/dp_arbiter.sv
// Round-robin, grant-locked arbiter sharing one register-file/ALU datapath between two
// sequencers. Define ARB_TIMEOUT_EN to revoke a grant held HOLD_MAX cycles under contention.
module dp_arbiter #(
    parameter int unsigned OPW      = 3,
    parameter int unsigned ARGW     = 2,
    parameter int unsigned HOLD_MAX = 64,
    parameter int unsigned CNTW     = 7
) (
    input  logic          CLK,
    input  logic          RST,
    dp_arbiter_if.master  bus
);
    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e state_q;
    logic   last_q;
    logic   gnt0_q;
    logic   gnt1_q;
    logic   own_req;

    if (HOLD_MAX < 2 || (HOLD_MAX >> CNTW) != 0) begin : g_bad_cfg
        $error("dp_arbiter: need HOLD_MAX >= 2 and 2**CNTW > HOLD_MAX");
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNTW-1:0] HoldLast = CNTW'(HOLD_MAX - 1);

    logic [CNTW-1:0] hold_cnt_q;
    logic            preempt_q;
    logic            oth_req;

    assign oth_req     = (state_q == StOwn1) ? bus.REQ0 : bus.REQ1;
    assign bus.PREEMPT = preempt_q;
`else
    assign bus.PREEMPT = 1'b0;
`endif

    assign own_req = (state_q == StOwn1) ? bus.REQ1 : bus.REQ0;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            preempt_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    // On a tie the requester not served last wins.
                    if (bus.REQ0 && (!bus.REQ1 || last_q)) begin
                        state_q <= StOwn0;
                        gnt0_q  <= 1'b1;
                    end else if (bus.REQ1) begin
                        state_q <= StOwn1;
                        gnt1_q  <= 1'b1;
                    end
                end
                StOwn0, StOwn1: begin
                    if (!own_req) begin
                        state_q    <= StIdle;
                        gnt0_q     <= 1'b0;
                        gnt1_q     <= 1'b0;
                        last_q     <= (state_q == StOwn1);
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_q <= '0;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (oth_req && hold_cnt_q == HoldLast) begin
                        state_q    <= StIdle;
                        gnt0_q     <= 1'b0;
                        gnt1_q     <= 1'b0;
                        last_q     <= (state_q == StOwn1);
                        hold_cnt_q <= '0;
                        preempt_q  <= 1'b1;
                    end else if (!oth_req) begin
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= StIdle;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.GNT0 = gnt0_q;
    assign bus.GNT1 = gnt1_q;
    assign bus.BUSY = gnt0_q | gnt1_q;
    assign bus.ZF0  = (state_q == StOwn0) & bus.ZERO_FLAG;
    assign bus.ZF1  = (state_q == StOwn1) & bus.ZERO_FLAG;

    always_comb begin
        bus.opcode   = '0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        if (state_q == StOwn0) begin
            bus.opcode   = bus.OPC0;
            bus.operand1 = bus.OPA0;
            bus.operand2 = bus.OPB0;
        end else if (state_q == StOwn1) begin
            bus.opcode   = bus.OPC1;
            bus.operand1 = bus.OPA1;
            bus.operand2 = bus.OPB1;
        end
    end
endmodule

// File: tb/tb_dp_arbiter.sv
// Self-checking bench for dp_arbiter: directed literal checks plus randomized traffic
// compared every cycle against an owner/last/wait-count model of the arbitration rules.
module tb_dp_arbiter;
    localparam int unsigned HM = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int RL = 3;
`else
    localparam int RL = 5;
`endif
    localparam int P = 2 * RL + 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dp_arbiter_if #(.OPW(3), .ARGW(2)) b ();

    dp_arbiter #(.OPW(3), .ARGW(2), .HOLD_MAX(HM), .CNTW(7)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: owner -1 means nobody holds the datapath.
    int m_owner;
    int m_last;
    int m_hold;
    bit m_preempt;
    bit m_valid;

    always @(posedge clk) begin : model
        int o;
        int l;
        int h;
        bit p;
        bit mine;
        o = m_owner;
        l = m_last;
        h = m_hold;
        p = 1'b0;
        if (!rst) begin
            o = -1;
            l = 1;
            h = 0;
        end else if (o < 0) begin
            if (b.REQ0 && b.REQ1) o = 1 - l;
            else if (b.REQ0) o = 0;
            else if (b.REQ1) o = 1;
        end else begin
            mine = (o == 0) ? b.REQ0 : b.REQ1;
            if (!mine) begin
                l = o;
                o = -1;
                h = 0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (((o == 0) ? b.REQ1 : b.REQ0) && h == int'(HM) - 1) begin
                l = o;
                o = -1;
                h = 0;
                p = 1'b1;
            end else if ((o == 0) ? b.REQ1 : b.REQ0) begin
                h = (h < 127) ? h + 1 : h;
            end else begin
                h = 0;
            end
`endif
        end
        m_owner   <= o;
        m_last    <= l;
        m_hold    <= h;
        m_preempt <= p;
        if (!rst) m_valid <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [12:0] act;
        logic [12:0] exp;
        logic [2:0]  eopc;
        logic [1:0]  eopa;
        logic [1:0]  eopb;
        if (!m_valid) return;
        eopc = 3'b000;
        eopa = 2'b00;
        eopb = 2'b00;
        if (m_owner == 0) begin
            eopc = b.OPC0;
            eopa = b.OPA0;
            eopb = b.OPB0;
        end else if (m_owner == 1) begin
            eopc = b.OPC1;
            eopa = b.OPA1;
            eopb = b.OPB1;
        end
        exp = {m_owner == 0, m_owner == 1, (m_owner == 0) & b.ZERO_FLAG,
               (m_owner == 1) & b.ZERO_FLAG, m_owner >= 0, m_preempt, eopc, eopa, eopb};
        act = {b.GNT0, b.GNT1, b.ZF0, b.ZF1, b.BUSY, b.PREEMPT, b.opcode, b.operand1,
               b.operand2};
        chk("model", 32'(act), 32'(exp));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            model_check();
        end
    endtask

    initial begin
        int c0;
        int c1;
        int eo;
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        b.REQ0      = 1'b0;
        b.REQ1      = 1'b0;
        b.OPC0      = '0;
        b.OPA0      = '0;
        b.OPB0      = '0;
        b.OPC1      = '0;
        b.OPA1      = '0;
        b.OPB1      = '0;
        b.ZERO_FLAG = 1'b0;
        step(2);
        chk("reset_outs", 32'({b.GNT0, b.GNT1, b.BUSY, b.PREEMPT, b.opcode}), 32'd0);

        // Single requester: one-edge latency, mux and flag forwarding.
        rst         = 1'b1;
        b.REQ0      = 1'b1;
        b.OPC0      = 3'b100;
        b.OPA0      = 2'b00;
        b.OPB0      = 2'b01;
        b.ZERO_FLAG = 1'b1;
        #1 chk("gnt0_not_yet", 32'(b.GNT0), 32'd0);
        step(1);
        chk("gnt0_single", 32'(b.GNT0), 32'd1);
        chk("opc_single", 32'({b.opcode, b.operand1, b.operand2}), 32'b100_00_01);
        chk("zf_fwd", 32'({b.ZF0, b.ZF1}), 32'b10);
        b.ZERO_FLAG = 1'b0;
        #1 chk("zf_track", 32'(b.ZF0), 32'd0);
        b.REQ0 = 1'b0;
        step(1);
        chk("release_nop", 32'({b.GNT0, b.opcode}), 32'd0);

        // Tie after reset: requester 0 first, then one NOP cycle, then requester 1.
        rst = 1'b0;
        step(1);
        rst    = 1'b1;
        b.REQ0 = 1'b1;
        b.REQ1 = 1'b1;
        b.OPC0 = 3'b011;
        b.OPC1 = 3'b101;
        b.OPA1 = 2'b10;
        step(1);
        chk("tie_gnt", 32'({b.GNT0, b.GNT1, b.opcode}), 32'b10_011);
        step(2);
        chk("tie_locked", 32'({b.GNT0, b.GNT1}), 32'b10);
        b.REQ0 = 1'b0;
        step(1);
        chk("handover_nop", 32'({b.GNT0, b.GNT1, b.opcode}), 32'd0);
        step(1);
        chk("handover_gnt1", 32'({b.GNT1, b.opcode, b.operand1}), 32'b1_101_10);
        b.OPC0 = 3'b111;
        #1 chk("nonowner_ignored", 32'({b.GNT0, b.opcode}), 32'b0_101);
        b.REQ1 = 1'b0;
        step(1);

        // Reset during a job aborts it; a lone requester 1 then wins.
        b.REQ0 = 1'b1;
        step(1);
        chk("mid_gnt0", 32'(b.GNT0), 32'd1);
        rst    = 1'b0;
        b.REQ0 = 1'b0;
        b.REQ1 = 1'b1;
        step(1);
        chk("mid_reset", 32'({b.GNT0, b.GNT1, b.opcode}), 32'd0);
        rst = 1'b1;
        step(1);
        chk("post_reset_gnt1", 32'(b.GNT1), 32'd1);
        b.REQ1 = 1'b0;
        step(1);

        // Contention while requester 0 holds its grant.
        rst = 1'b0;
        step(1);
        rst    = 1'b1;
        b.REQ0 = 1'b1;
        step(1);
        chk("to_gnt0", 32'(b.GNT0), 32'd1);
        b.REQ1 = 1'b1;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("to_hold", 32'({b.GNT0, b.PREEMPT}), 32'b10);
        end
        step(1);
        chk("to_preempt", 32'({b.GNT0, b.GNT1, b.PREEMPT}), 32'b001);
        step(1);
        chk("to_regrant", 32'({b.GNT0, b.GNT1, b.PREEMPT}), 32'b010);
`else
        step(20);
        chk("no_timeout", 32'({b.GNT0, b.GNT1, b.PREEMPT}), 32'b100);
`endif
        b.REQ0 = 1'b0;
        b.REQ1 = 1'b0;
        rst    = 1'b0;
        step(1);
        rst = 1'b1;

        // Both keep requesting and release after RL owned cycles: strict alternation.
        b.REQ0 = 1'b1;
        b.REQ1 = 1'b1;
        c0     = 0;
        c1     = 0;
        for (int i = 0; i < 3 * P; i++) begin
            step(1);
            eo = (i % P < RL) ? 0 : (i % P == RL) ? -1 : (i % P < 2 * RL + 1) ? 1 : -1;
            chk("alternate", 32'({b.GNT0, b.GNT1}), 32'({eo == 0, eo == 1}));
            if (b.GNT0) begin
                c0++;
                if (c0 == RL) begin
                    b.REQ0 = 1'b0;
                    c0     = 0;
                end
            end else begin
                b.REQ0 = 1'b1;
            end
            if (b.GNT1) begin
                c1++;
                if (c1 == RL) begin
                    b.REQ1 = 1'b0;
                    c1     = 0;
                end
            end else begin
                b.REQ1 = 1'b1;
            end
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(63) != 0);
            if (b.REQ0) b.REQ0 = ($urandom_range(5) != 0);
            else        b.REQ0 = ($urandom_range(2) == 0);
            if (b.REQ1) b.REQ1 = ($urandom_range(5) != 0);
            else        b.REQ1 = ($urandom_range(2) == 0);
            b.OPC0      = 3'($urandom);
            b.OPA0      = 2'($urandom);
            b.OPB0      = 2'($urandom);
            b.OPC1      = 3'($urandom);
            b.OPA1      = 2'($urandom);
            b.OPB1      = 2'($urandom);
            b.ZERO_FLAG = 1'($urandom);
            #1 model_check();
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
